// File: rtl/monobit_pkg.sv
// Shared encodings for the monobit bit generator and the monobit frequency tester.
package monobit_pkg;

  typedef enum logic [2:0] {
    MODE_LFSR = 3'd0,
    MODE_ZERO = 3'd1,
    MODE_ONE  = 3'd2,
    MODE_ALT  = 3'd3,
    MODE_AND  = 3'd4,
    MODE_OR   = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  function automatic logic mode_uses_lfsr(input logic [2:0] m);
    return (m == MODE_LFSR) || (m == MODE_AND) || (m == MODE_OR);
  endfunction

endpackage

// File: rtl/monobit_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and enable-gated step; a zero seed is replaced by SEED_INIT.
module monobit_lfsr16
  import monobit_pkg::*;
#(
  parameter logic [15:0] SEED_INIT = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_en,
  output logic [1:0]  o_top
);

  logic [15:0] r_s;
  logic        w_fb;

  assign w_fb  = ^(r_s & LFSR_TAPS);
  assign o_top = r_s[15:14];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= SEED_INIT;
    end else if (i_load) begin
      r_s <= (i_seed == 16'h0000) ? SEED_INIT : i_seed;
    end else if (i_en) begin
      r_s <= {r_s[14:0], w_fb};
    end
  end

endmodule

// File: rtl/monobit_bitgen.sv
// Framed test-bit source: emits block_len bits over a valid/ready link and tallies the ones sent.
// Optional back-to-back streaming of blocks is enabled with `define MONOBIT_BITGEN_CONT_EN.
module monobit_bitgen #(
  parameter int          BLOCK_W      = 10,
  parameter logic [15:0] SEED_DEFAULT = monobit_pkg::SEED_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [15:0]        seed,
  input  logic [2:0]         mode,
  input  logic [BLOCK_W-1:0] block_len,
  input  logic               start,
`ifdef MONOBIT_BITGEN_CONT_EN
  input  logic               cont,
`endif
  output logic               bit_out,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               bit_last,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W:0]   ones_count,
  output logic [1:0]         dbg_state
);

  import monobit_pkg::*;

  // Handshake: a bit transfers on any rising clk where bit_valid && bit_ready; while
  // bit_valid is high and bit_ready low, bit_out and bit_last hold their values.

  localparam logic [BLOCK_W:0] ONE_W = (BLOCK_W+1)'(1);

  state_t           r_state, w_next;
  logic [2:0]       r_mode;
  logic [BLOCK_W:0] r_rem, r_ones, w_len;
  logic             r_alt;
  logic [1:0]       w_top;
  logic             w_hs, w_last, w_bit, w_start, w_seed_ld;
  logic             w_restart, w_restart_d;
  logic [BLOCK_W:0] w_len_reload;

  assign w_start   = (r_state == IDLE) && start;
  assign w_seed_ld = (r_state == IDLE) && seed_load;
  assign w_hs      = bit_valid && bit_ready;
  assign w_last    = (r_state == RUN) && (r_rem == ONE_W);
  assign w_len     = (block_len == '0) ? {1'b1, {BLOCK_W{1'b0}}} : {1'b0, block_len};

`ifdef MONOBIT_BITGEN_CONT_EN
  logic [BLOCK_W:0] r_len;
  logic             r_restart;

  assign w_restart    = w_hs && w_last && cont;
  assign w_restart_d  = r_restart;
  assign w_len_reload = r_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_restart <= 1'b0;
    end else begin
      r_restart <= w_restart;
      if (w_start) r_len <= w_len;
    end
  end
`else
  assign w_restart    = 1'b0;
  assign w_restart_d  = 1'b0;
  assign w_len_reload = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_hs && w_last && !w_restart) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_bit = 1'b0;
    case (r_mode)
      MODE_LFSR: w_bit = w_top[1];
      MODE_ONE:  w_bit = 1'b1;
      MODE_ALT:  w_bit = r_alt;
      MODE_AND:  w_bit = w_top[1] & w_top[0];
      MODE_OR:   w_bit = w_top[1] | w_top[0];
      default:   w_bit = 1'b0;
    endcase
  end

  // The cycle after a back-to-back restart shows the finished total, so the tally restarts from 0 there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= '0;
      r_rem  <= '0;
      r_ones <= '0;
      r_alt  <= 1'b0;
    end else if (w_start) begin
      r_mode <= mode;
      r_rem  <= w_len;
      r_ones <= '0;
      r_alt  <= 1'b1;
    end else if (w_hs) begin
      r_ones <= (w_restart_d ? '0 : r_ones) + (BLOCK_W+1)'(bit_out);
      if (w_restart) begin
        r_rem <= w_len_reload;
        r_alt <= 1'b1;
      end else begin
        r_rem <= r_rem - ONE_W;
        r_alt <= ~r_alt;
      end
    end else if (w_restart_d) begin
      r_ones <= '0;
    end
  end

  monobit_lfsr16 #(
    .SEED_INIT(SEED_DEFAULT)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_seed_ld),
    .i_seed (seed),
    .i_en   (w_hs && mode_uses_lfsr(r_mode)),
    .o_top  (w_top)
  );

  assign bit_valid  = (r_state == RUN);
  assign bit_out    = (r_state == RUN) && w_bit;
  assign bit_last   = w_last;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE) || w_restart_d;
  assign ones_count = r_ones;
  assign dbg_state  = r_state;

endmodule
